// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_arbiter
// Purpose  : Round-robin sharing of one 16-bit SPI read master among NREQ
//            requesters, with ENA/FIN sequencing and a chip-select-high gap.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int TW          = 7
) (
    input  logic            spi_clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            ena_o,
    input  logic            fin_i,
    input  logic [15:0]     data_in_i,
    output logic [15:0]     rd_data_o,
    output logic [NREQ-1:0] rd_valid_o,
    output logic            busy_o,
    output logic            timeout_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0]   c_TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]   c_GAP_LAST = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0]   c_CNT_MAX  = {TW{1'b1}};
    localparam logic [NREQ-1:0] c_ONE      = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic            ena_q;
    logic [15:0]     rd_data_q;
    logic [NREQ-1:0] rd_valid_q;
    logic            busy_q;
    logic            timeout_q;
    logic [TW-1:0]   cnt_q;
    logic [PW-1:0]   rr_ptr_q;

    logic [TW-1:0]   w_cnt_inc;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_win;
    logic            w_found;

    assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + TW'(1);

    // Search starts just after the last winner, so a persistent requester
    // only wins again once every other requester has had its turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = PW'((int'(rr_ptr_q) + i) % NREQ);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge spi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ena_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            rr_ptr_q   <= PW'(NREQ - 1);
        end else begin
            rd_valid_q <= '0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        gnt_q    <= c_ONE << w_win;
                        ena_q    <= 1'b1;
                        rr_ptr_q <= w_win;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= w_cnt_inc;
                    if (fin_i) begin
                        rd_data_q <= data_in_i;
                        state_q   <= S_CAPTURE;
                    end else if (cnt_q == c_TO_LAST) begin
                        // Restart the count so an aborted transfer still gets a full gap.
                        ena_q     <= 1'b0;
                        gnt_q     <= '0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_CAPTURE: begin
                    rd_valid_q <= gnt_q;
                    ena_q      <= 1'b0;
                    gnt_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= S_GAP;
                end
                S_GAP: begin
                    cnt_q <= w_cnt_inc;
                    if ((cnt_q >= c_GAP_LAST) && !fin_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    ena_q   <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign ena_o      = ena_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_arbiter
// Purpose  : Directed self-checking bench for spi_xfer_arbiter with a simple
//            SPI master model (FIN some cycles after ENA, FIN tail after ENA drops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_arbiter;

    localparam int NREQ        = 4;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int TW          = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            fin = 1'b0;
    logic [15:0]     data_in = '0;
    logic [NREQ-1:0] gnt;
    logic            ena;
    logic [15:0]     rd_data;
    logic [NREQ-1:0] rd_valid;
    logic            busy;
    logic            timeout;

    spi_xfer_arbiter #(
        .NREQ(NREQ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .TW(TW)
    ) dut (
        .spi_clk_i (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .ena_o     (ena),
        .fin_i     (fin),
        .data_in_i (data_in),
        .rd_data_o (rd_data),
        .rd_valid_o(rd_valid),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Master model configuration and state
    int          m_lat   = 19;
    int          m_tail  = 1;
    bit          m_nofin = 1'b0;
    logic [15:0] m_data  = 16'h0000;
    int          m_cnt   = 0;
    int          m_tl    = 0;

    // Monitor records
    int              cycle = 0;
    logic            ena_prev = 1'b0;
    logic            busy_prev = 1'b0;
    int              ena_rise_cyc = 0;
    int              rv_cyc = 0;
    int              to_cnt = 0;
    int              to_cyc = 0;
    int              fin_fall_cyc = 0;
    int              busy_fall_cyc = 0;
    int              ena_low_run = 1000;
    int              min_gap = 1000;
    logic [NREQ-1:0] grants[$];
    logic [NREQ-1:0] rvs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the master model.
    task automatic cyc();
        @(negedge clk);
        cycle++;
        if (ena && !ena_prev) begin
            grants.push_back(gnt);
            ena_rise_cyc = cycle;
            if (ena_low_run < min_gap) min_gap = ena_low_run;
        end
        if (ena) ena_low_run = 0;
        else     ena_low_run++;
        if (rd_valid != '0) begin
            rvs.push_back(rd_valid);
            rv_cyc = cycle;
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cycle;
        end
        if (!busy && busy_prev) busy_fall_cyc = cycle;
        ena_prev  = ena;
        busy_prev = busy;

        if (ena) begin
            m_cnt++;
            if (!m_nofin && !fin && m_cnt >= m_lat) begin
                fin     = 1'b1;
                data_in = m_data;
                m_tl    = m_tail;
            end
        end else begin
            m_cnt = 0;
            if (fin) begin
                if (m_tl > 0) m_tl--;
                else begin
                    fin = 1'b0;
                    fin_fall_cyc = cycle;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        fin = 1'b0;
        m_cnt = 0;
        m_lat = 19; m_tail = 1; m_nofin = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        grants.delete();
        rvs.delete();
        to_cnt = 0;
        min_gap = 1000;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        cyc();
        while (busy && n < max) begin
            cyc();
            n++;
        end
        if (busy) check("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic one_xfer(input logic [NREQ-1:0] r, input logic [15:0] d);
        m_data = d;
        req = r;
        cyc();
        req = '0;
        wait_idle(300);
    endtask

    initial begin
        // 1: reset values, single transfer from requester 0
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ena_busy_to", {29'd0, ena, busy, timeout}, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        one_xfer(4'b0001, 16'hA5C3);
        check("t1_ngrants", grants.size(), 1);
        check("t1_gnt", 32'(grants[0]), 32'h1);
        check("t1_nrv", rvs.size(), 1);
        check("t1_rv", 32'(rvs[0]), 32'h1);
        check("t1_data", 32'(rd_data), 32'hA5C3);
        check("t1_latency", 32'(rv_cyc - ena_rise_cyc), 32'd20);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: all requesting -> strict rotation starting at 0
        do_reset();
        check("t2_rst_rd_data", 32'(rd_data), 32'd0);
        m_data = 16'h1234;
        req = 4'b1111;
        for (int n = 0; n < 1000 && grants.size() < 5; n++) cyc();
        req = '0;
        wait_idle(300);
        check("t2_ngrants", grants.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_gnt%0d", i), 32'(grants[i]), 32'(4'b0001 << (i % 4)));
            check($sformatf("t2_rv%0d", i), 32'(rvs[i]), 32'(4'b0001 << (i % 4)));
        end
        check("t2_ena_gap", 32'(min_gap), 32'(GAP_CYC + 1));

        // 3: FIN never arrives -> timeout, then a normal transfer
        do_reset();
        m_nofin = 1'b1;
        one_xfer(4'b0010, 16'hDEAD);
        check("t3_to_cnt", 32'(to_cnt), 32'd1);
        // one START cycle, then TIMEOUT_CYC cycles in WAIT_FIN before the pulse
        check("t3_to_delay", 32'(to_cyc - ena_rise_cyc), 32'(TIMEOUT_CYC + 1));
        check("t3_nrv", rvs.size(), 0);
        check("t3_ena", 32'(ena), 32'd0);
        m_nofin = 1'b0;
        one_xfer(4'b0100, 16'h0F0F);
        check("t3_next_gnt", 32'(grants[grants.size()-1]), 32'h4);
        check("t3_next_rv", rvs.size() == 1 ? 32'(rvs[0]) : 32'hFFFF, 32'h4);
        check("t3_next_data", 32'(rd_data), 32'h0F0F);

        // 4: FIN stuck high after capture holds GAP
        do_reset();
        m_tail = 12;
        one_xfer(4'b0001, 16'h5555);
        check("t4_nrv", rvs.size(), 1);
        check("t4_fin_hold", 32'(fin_fall_cyc - rv_cyc) >= 32'd10 ? 32'd1 : 32'd0, 32'd1);
        check("t4_busy_after_fin", 32'(busy_fall_cyc - fin_fall_cyc), 32'd1);

        // 5: async reset mid-transfer, then rr_ptr restart
        do_reset();
        m_data = 16'hBEEF;
        req = 4'b0001;
        cyc();
        req = '0;
        repeat (10) cyc();
        check("t5_pre_ena", 32'(ena), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_async_out", {gnt, rd_valid, ena, busy, timeout}, '0);
        cyc();
        rst = 1'b0;
        grants.delete();
        rvs.delete();
        one_xfer(4'b1000, 16'hC0DE);
        check("t5_gnt", grants.size() == 1 ? 32'(grants[0]) : 32'hFF, 32'h8);
        check("t5_rv", rvs.size() == 1 ? 32'(rvs[0]) : 32'hFF, 32'h8);

        // 6: requester drops REQ during its transfer
        do_reset();
        m_data = 16'h7E57;
        req = 4'b0100;
        repeat (5) cyc();
        req = '0;
        wait_idle(300);
        check("t6_rv", rvs.size() == 1 ? 32'(rvs[0]) : 32'hFF, 32'h4);
        check("t6_data", 32'(rd_data), 32'h7E57);

        // 7: FIN arrives on the last timeout cycle -> capture wins
        do_reset();
        m_lat = TIMEOUT_CYC + 1;
        one_xfer(4'b0010, 16'h9999);
        check("t7_to_cnt", 32'(to_cnt), 32'd0);
        check("t7_rv", rvs.size() == 1 ? 32'(rvs[0]) : 32'hFF, 32'h2);
        check("t7_data", 32'(rd_data), 32'h9999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
